debug_unit_receive: RTL and testbench
=====================================

// Module: debug_unit_receive
// PURPOSE
//  Receive half of the MIPS debug unit, sitting between the UART receiver and the
//  instruction memory / pipeline control.
//  Decodes a byte stream into:
//   - a load command;
//   - 32-bit instruction words, assembled MSB first and written to instruction memory;
//   - a halt sentinel;
//   - an execution-mode selection and step pulses.
// PARAMETERS
//  NB_DATA   32  instruction/memory word width (fixed 4 bytes per word)
//  NB_BYTE   8   UART byte width
//  NB_STATE  3   width of exported state code
// PORTS
//  i_clock                input   1        system clock; single clock domain
//  i_reset                input   1        synchronous, active-high reset
//  i_rx_data              input   NB_BYTE  byte from UART receiver
//  i_rx_done              input   1        1-cycle strobe: i_rx_data valid this cycle
//  o_execution_mode       output  1        1 = step mode, 0 = continuous
//  o_execution_step       output  1        1-cycle step pulse (step mode only)
//  o_enable_write_memory  output  1        instruction-memory write enable / load phase active
//  o_done_write_memory    output  1        1-cycle pulse: o_data_memory holds a complete word
//  o_data_memory          output  NB_DATA  last assembled instruction word
//  o_state                output  NB_STATE current FSM state code
// BEHAVIOUR
//  - All outputs registered; they update on the i_clock edge that samples i_rx_done=1.
//  - Reset (sync, highest priority, overrides i_rx_done):
//     - state=IDLE, byte counter=0;
//     - all outputs 0, including o_data_memory=0.
//  - Bytes are consumed only in cycles with i_rx_done=1; otherwise state and data hold.
//  - States (o_state code):
//     - IDLE=0
//     - LOAD=1
//     - WAIT_MODE=2
//     - RUN_CONT=3
//     - RUN_STEP=4
//     - codes 5..7 unused -> IDLE.
//  - IDLE:
//     - byte 0x55 (CMD_LOAD) -> LOAD; o_enable_write_memory=1; counter=0.
//     - any other byte is ignored.
//  - LOAD:
//     - each byte shifts into the word: word = {word[23:0], byte}; counter += 1 (2-bit).
//     - on the 4th byte (counter wraps 3->0):
//        - o_data_memory <= assembled word, with the 4th byte in bits [7:0];
//        - o_done_write_memory = 1 for exactly one cycle.
//     - if that word == 32'hFFFFFFFF (HALT) -> WAIT_MODE. The halt word is still presented
//       and pulsed like any other word.
//     - o_enable_write_memory stays 1 throughout LOAD and WAIT_MODE.
//  - WAIT_MODE (halt received, waiting for the mode byte):
//     - 0x01 -> RUN_STEP, o_execution_mode=1.
//     - 0x00 -> RUN_CONT, o_execution_mode=0.
//     - In both cases o_enable_write_memory=0 on that same edge.
//     - other bytes ignored.
//  - RUN_STEP:
//     - byte 0x01 (CMD_STEP) -> o_execution_step=1 for exactly one cycle.
//     - other bytes ignored; remain in RUN_STEP.
//  - RUN_CONT: all bytes ignored.
//  - Both run states exit only via reset.
//  - o_done_write_memory and o_execution_step are 0 in every cycle that does not
//    generate a pulse.
//  - o_data_memory holds its value between words and after leaving LOAD.
//  - A byte is consumed each cycle i_rx_done is high, including back-to-back strobes.
//  - Reset mid-word discards the partial word and clears the counter.
// STRUCTURE
//  - Shared package/include holds:
//     - state codes;
//     - CMD_LOAD=8'h55, CMD_STEP_MODE=8'h01, CMD_CONT_MODE=8'h00, CMD_STEP=8'h01;
//     - HALT_WORD=32'hFFFFFFFF.
//  - Single module, no sub-modules:
//     - FSM;
//     - 2-bit byte counter;
//     - 32-bit shift register;
//     - registered outputs.
// TESTING
//  1. Reset, then no strobes -> state=0; all outputs 0; byte 0xAA in IDLE -> still IDLE, enable=0.
//  2. 0x55 -> enable=1, state=1.
//     Then AA,BB,CC,DD -> after the 4th edge: done=1, data=0xAABBCCDD; done=0 the next cycle.
//  3. 11,22,33,44 then 1F,2F,3F,4F -> data 0x11223344 then 0x1F2F3F4F,
//     one done pulse per word, enable stays 1.
//  4. FF x4 -> data=0xFFFFFFFF, done=1, enable=1, state=2.
//     Then 0x01 -> enable=0, mode=1, state=4.
//  5. Step mode: idle 2 cycles, send 0x01 -> step=1 for one cycle.
//     Repeat -> second pulse; non-0x01 byte -> no pulse.
//  6. Reset after 2 bytes of a word -> IDLE, outputs 0.
//     A fresh 0x55 + 4 bytes assembles correctly.

Source files
------------

// File: rtl/debug_unit_receive_pkg.sv
// Shared command bytes, halt sentinel and state codes for the debug unit receive path.
package debug_unit_receive_pkg;

  localparam int NB_DATA  = 32;
  localparam int NB_BYTE  = 8;
  localparam int NB_STATE = 3;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_MODE = 3'd2,
    ST_RUN_CONT  = 3'd3,
    ST_RUN_STEP  = 3'd4
  } state_t;

  localparam logic [NB_BYTE-1:0] CMD_LOAD      = 8'h55;
  localparam logic [NB_BYTE-1:0] CMD_STEP_MODE = 8'h01;
  localparam logic [NB_BYTE-1:0] CMD_CONT_MODE = 8'h00;
  localparam logic [NB_BYTE-1:0] CMD_STEP      = 8'h01;
  localparam logic [NB_DATA-1:0] HALT_WORD     = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_unit_receive.sv
// Decodes the UART byte stream into instruction-memory writes, a halt sentinel,
// execution-mode selection and step pulses. All outputs are registered.
module debug_unit_receive
  import debug_unit_receive_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_done,
  output logic                o_execution_mode,
  output logic                o_execution_step,
  output logic                o_enable_write_memory,
  output logic                o_done_write_memory,
  output logic [NB_DATA-1:0]  o_data_memory,
  output logic [NB_STATE-1:0] o_state
);

  // Input handshake: i_rx_done is a one-cycle valid strobe with no ready;
  // every cycle it is high one byte is consumed, back-to-back included.

  state_t               state, state_next;
  logic [1:0]           count, count_next;
  logic [NB_DATA-1:0]   shift, shift_next;
  logic [NB_DATA-1:0]   word_in;
  logic                 mode_next, step_next, enable_next, done_next;
  logic [NB_DATA-1:0]   data_next;

  assign word_in = {shift[NB_DATA-NB_BYTE-1:0], i_rx_data};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state                 <= ST_IDLE;
      count                 <= 2'd0;
      shift                 <= '0;
      o_execution_mode      <= 1'b0;
      o_execution_step      <= 1'b0;
      o_enable_write_memory <= 1'b0;
      o_done_write_memory   <= 1'b0;
      o_data_memory         <= '0;
    end else begin
      state                 <= state_next;
      count                 <= count_next;
      shift                 <= shift_next;
      o_execution_mode      <= mode_next;
      o_execution_step      <= step_next;
      o_enable_write_memory <= enable_next;
      o_done_write_memory   <= done_next;
      o_data_memory         <= data_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    shift_next  = shift;
    mode_next   = o_execution_mode;
    enable_next = o_enable_write_memory;
    data_next   = o_data_memory;
    step_next   = 1'b0;
    done_next   = 1'b0;

    if (i_rx_done) begin
      case (state)
        ST_IDLE: begin
          if (i_rx_data == CMD_LOAD) begin
            state_next  = ST_LOAD;
            enable_next = 1'b1;
            count_next  = 2'd0;
          end
        end
        ST_LOAD: begin
          shift_next = word_in;
          count_next = count + 2'd1;
          // Fourth byte completes the word; the halt word is still written out.
          if (count == 2'd3) begin
            data_next = word_in;
            done_next = 1'b1;
            if (word_in == HALT_WORD) state_next = ST_WAIT_MODE;
          end
        end
        ST_WAIT_MODE: begin
          if (i_rx_data == CMD_STEP_MODE) begin
            state_next  = ST_RUN_STEP;
            mode_next   = 1'b1;
            enable_next = 1'b0;
          end else if (i_rx_data == CMD_CONT_MODE) begin
            state_next  = ST_RUN_CONT;
            mode_next   = 1'b0;
            enable_next = 1'b0;
          end
        end
        ST_RUN_STEP: begin
          if (i_rx_data == CMD_STEP) step_next = 1'b1;
        end
        ST_RUN_CONT: begin
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (!(state inside {ST_IDLE, ST_LOAD, ST_WAIT_MODE, ST_RUN_CONT, ST_RUN_STEP})) begin
      state_next = ST_IDLE;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_debug_unit_receive.sv
// Directed bench for debug_unit_receive: load, multi-word, halt, step/continuous modes, reset mid-word.
module tb_debug_unit_receive;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        mode, step, enable, done_wr;
  logic [31:0] data;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debug_unit_receive dut (
    .i_clock               (clk),
    .i_reset               (rst),
    .i_rx_data             (rx_data),
    .i_rx_done             (rx_done),
    .o_execution_mode      (mode),
    .o_execution_step      (step),
    .o_enable_write_memory (enable),
    .o_done_write_memory   (done_wr),
    .o_data_memory         (data),
    .o_state               (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reset is asserted together with a strobe carrying CMD_LOAD to show reset wins.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_done = 1'b1; rx_data = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0; rx_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rx_done = 1'b0; rx_data = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic chk_outputs(input string tag, input logic [2:0] st, input logic en,
                             input logic dn, input logic md, input logic sp, input logic [31:0] d);
    chk({tag, "_state"},  {29'd0, state}, {29'd0, st});
    chk({tag, "_enable"}, {31'd0, enable}, {31'd0, en});
    chk({tag, "_done"},   {31'd0, done_wr}, {31'd0, dn});
    chk({tag, "_mode"},   {31'd0, mode}, {31'd0, md});
    chk({tag, "_step"},   {31'd0, step}, {31'd0, sp});
    chk({tag, "_data"},   data, d);
  endtask

  initial begin
    rst = 1'b0; rx_done = 1'b0; rx_data = 8'h00;

    // 1: reset state, then a foreign byte in IDLE is ignored
    do_reset();
    idle_cycle();
    chk_outputs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    send_byte(8'hAA);
    chk_outputs("idle_aa", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // 2: load command and one word with a done pulse
    send_byte(8'h55);
    chk_outputs("load_cmd", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    chk_outputs("word1_b3", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    send_byte(8'hDD);
    chk_outputs("word1", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hAABBCCDD);
    idle_cycle();
    chk_outputs("word1_after", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hAABBCCDD);

    // 3: two back-to-back words, gaps between bytes of the second
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk_outputs("word2", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11223344);
    send_byte(8'h1F);
    chk_outputs("word3_b1", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11223344);
    idle_cycle();
    send_byte(8'h2F); idle_cycle(); send_byte(8'h3F); send_byte(8'h4F);
    chk_outputs("word3", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1F2F3F4F);

    // 4: halt word, ignored byte in WAIT_MODE, then step mode
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    chk_outputs("halt", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
    send_byte(8'h7E);
    chk_outputs("wait_ignore", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF);
    send_byte(8'h01);
    chk_outputs("step_mode", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);

    // 5: step pulses
    idle_cycle(); idle_cycle();
    chk_outputs("step_idle", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);
    send_byte(8'h01);
    chk_outputs("step1", 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
    idle_cycle();
    chk_outputs("step1_after", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);
    send_byte(8'h01);
    chk_outputs("step2", 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
    send_byte(8'h02);
    chk_outputs("step_other", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);
    send_byte(8'h55);
    chk_outputs("step_55", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);

    // 6: reset mid-word discards the partial word; fresh load is clean
    do_reset();
    send_byte(8'h55); send_byte(8'hDE); send_byte(8'hAD);
    do_reset();
    chk_outputs("mid_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    send_byte(8'h55);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    chk_outputs("fresh_word", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12345678);

    // Continuous mode: step byte produces no pulse
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    chk_outputs("halt2", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
    send_byte(8'h00);
    chk_outputs("cont_mode", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF);
    send_byte(8'h01);
    chk_outputs("cont_ignore", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
